cpu: RTL and testbench

//  Single-cycle 32-bit MIPS-style processor core: one instruction completes per clk.

---
 rtl/cpu.sv | 184 ++++++++++++++++++
 tb/tb_cpu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu : single-cycle 32-bit MIPS-style core
//
// One instruction completes per clk. Instruction and data memories sit outside
// the core: the core presents pc and receives instr in the same cycle, and
// presents aluout/writedata/memwrite and receives readdata in the same cycle.
// Internally: PC register, 32x32 register file, ALU, main and ALU decoders.
//
// Ports
//   clk        in   1  clock, all state updates on posedge
//   reset      in   1  asynchronous active-low reset (0 = reset)
//   pc         out  N  address of the current instruction (registered)
//   instr      in   N  instruction at pc
//   memwrite   out  1  data-memory write enable (SW only, 0 during reset)
//   aluout     out  N  ALU result, also the data-memory address for lw/sw
//   writedata  out  N  store data = RF[rt]
//   readdata   in   N  data-memory read data at aluout
// -----------------------------------------------------------------------------
module cpu #(
    parameter int              N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] pc,
    input  logic [N-1:0] instr,
    output logic         memwrite,
    output logic [N-1:0] aluout,
    output logic [N-1:0] writedata,
    input  logic [N-1:0] readdata
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd1;
    localparam logic [5:0] OP_SW    = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd5;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Instruction fields
    logic [5:0]   w_op;
    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [5:0]   w_funct;
    logic [N-1:0] w_imm;
    logic [25:0]  w_target;

    assign w_op     = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_funct  = instr[5:0];
    assign w_imm    = {{(N-16){instr[15]}}, instr[15:0]};
    assign w_target = instr[25:0];

    // State
    logic [N-1:0] r_pc;
    logic [N-1:0] r_rf [0:31];

    // Register file reads; entry 0 is never written so it always reads 0.
    logic [N-1:0] w_rs_val;
    logic [N-1:0] w_rt_val;

    assign w_rs_val = r_rf[w_rs];
    assign w_rt_val = r_rf[w_rt];

    // Decoder
    alu_op_t      w_alu_op;
    logic         w_use_rt;     // ALU B operand from RF[rt] instead of imm
    logic         w_rf_we;
    logic [4:0]   w_rf_wa;
    logic         w_mem_to_rf;
    logic         w_is_sw;
    logic         w_is_beq;
    logic         w_is_j;

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_use_rt    = 1'b0;
        w_rf_we     = 1'b0;
        w_rf_wa     = w_rt;
        w_mem_to_rf = 1'b0;
        w_is_sw     = 1'b0;
        w_is_beq    = 1'b0;
        w_is_j      = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_use_rt = 1'b1;
                w_rf_wa  = w_rd;
                // Unknown funct behaves as a NOP: ALU still adds, no writeback.
                case (w_funct)
                    6'h20: begin w_alu_op = ALU_ADD; w_rf_we = 1'b1; end
                    6'h22: begin w_alu_op = ALU_SUB; w_rf_we = 1'b1; end
                    6'h24: begin w_alu_op = ALU_AND; w_rf_we = 1'b1; end
                    6'h25: begin w_alu_op = ALU_OR;  w_rf_we = 1'b1; end
                    6'h2A: begin w_alu_op = ALU_SLT; w_rf_we = 1'b1; end
                    default: ;
                endcase
            end
            OP_LW: begin
                w_rf_we     = 1'b1;
                w_mem_to_rf = 1'b1;
            end
            OP_SW:   w_is_sw = 1'b1;
            OP_ADDI: w_rf_we = 1'b1;
            OP_BEQ: begin
                w_use_rt = 1'b1;
                w_alu_op = ALU_SUB;
                w_is_beq = 1'b1;
            end
            OP_J:    w_is_j = 1'b1;
            default: ;
        endcase
    end

    // ALU
    logic [N-1:0] w_src_b;
    logic [N-1:0] w_alu_y;

    assign w_src_b = w_use_rt ? w_rt_val : w_imm;

    always_comb begin
        w_alu_y = '0;
        case (w_alu_op)
            ALU_ADD: w_alu_y = w_rs_val + w_src_b;
            ALU_SUB: w_alu_y = w_rs_val - w_src_b;
            ALU_AND: w_alu_y = w_rs_val & w_src_b;
            ALU_OR:  w_alu_y = w_rs_val | w_src_b;
            ALU_SLT: w_alu_y = {{(N-1){1'b0}}, ($signed(w_rs_val) < $signed(w_src_b))};
            default: w_alu_y = '0;
        endcase
    end

    // Next PC
    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_pc_next;

    assign w_pc_plus4 = r_pc + N'(4);

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_is_j)
            w_pc_next = {w_pc_plus4[N-1:N-4], w_target, 2'b00};
        else if (w_is_beq && (w_alu_y == '0))
            w_pc_next = w_pc_plus4 + {w_imm[N-3:0], 2'b00};
    end

    logic [N-1:0] w_rf_wd;
    assign w_rf_wd = w_mem_to_rf ? readdata : w_alu_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_rf_we && (w_rf_wa != 5'd0)) begin
            r_rf[w_rf_wa] <= w_rf_wd;
        end
    end

    assign pc        = r_pc;
    assign aluout    = w_alu_y;
    assign writedata = w_rt_val;
    // Gated with reset so no store can reach memory while the core is held.
    assign memwrite  = w_is_sw & reset;

endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu : directed table-driven bench for the single-cycle cpu core.
// Each table row is one instruction: inputs driven after a negedge, outputs
// compared 1 ns later, state commits at the following posedge. Register
// contents are observed through later instructions (aluout = RF[rs]+...,
// writedata = RF[rt]).
// -----------------------------------------------------------------------------
module tb_cpu;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int n_vec;
    int n_miss;

    cpu #(.N(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic        chk_alu;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
        logic        exp_mw;
    } vec_t;

    vec_t vecs [0:23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic show(input string tag);
        $display("%s pc=%08h instr=%08h aluout=%08h writedata=%08h memwrite=%0b",
                 tag, pc, instr, aluout, writedata, memwrite);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        //            instr         rdata         pc      chk   aluout        wdata         mw
        vecs[0]  = '{32'h050C0004, 32'hDEADBEEF, 32'h00, 1'b1, 32'h00000004, 32'h00000000, 1'b0}; // lw $12,4($8)
        vecs[1]  = '{32'h0C0D000F, 32'h0,        32'h04, 1'b1, 32'h0000000F, 32'h00000000, 1'b0}; // addi $13,$0,15
        vecs[2]  = '{32'h09820004, 32'h0,        32'h08, 1'b1, 32'hDEADBEF3, 32'h00000000, 1'b1}; // sw $2,4($12)
        vecs[3]  = '{32'h05830004, 32'h12345678, 32'h0C, 1'b1, 32'hDEADBEF3, 32'h00000000, 1'b0}; // lw $3,4($12)
        vecs[4]  = '{32'h09A30000, 32'h0,        32'h10, 1'b1, 32'h0000000F, 32'h12345678, 1'b1}; // sw $3,0($13)
        vecs[5]  = '{32'h0C010005, 32'h0,        32'h14, 1'b1, 32'h00000005, 32'h00000000, 1'b0}; // addi $1,$0,5
        vecs[6]  = '{32'h0C020007, 32'h0,        32'h18, 1'b1, 32'h00000007, 32'h00000000, 1'b0}; // addi $2,$0,7
        vecs[7]  = '{32'h00221822, 32'h0,        32'h1C, 1'b1, 32'hFFFFFFFE, 32'h00000007, 1'b0}; // sub $3,$1,$2
        vecs[8]  = '{32'h0022202A, 32'h0,        32'h20, 1'b1, 32'h00000001, 32'h00000007, 1'b0}; // slt $4,$1,$2
        vecs[9]  = '{32'h00622824, 32'h0,        32'h24, 1'b1, 32'h00000006, 32'h00000007, 1'b0}; // and $5,$3,$2
        vecs[10] = '{32'h00613025, 32'h0,        32'h28, 1'b1, 32'hFFFFFFFF, 32'h00000005, 1'b0}; // or $6,$3,$1
        vecs[11] = '{32'h08A40000, 32'h0,        32'h2C, 1'b1, 32'h00000006, 32'h00000001, 1'b1}; // sw $4,0($5)
        vecs[12] = '{32'h00C13820, 32'h0,        32'h30, 1'b1, 32'h00000004, 32'h00000005, 1'b0}; // add $7,$6,$1 (wraps)
        vecs[13] = '{32'h0C000009, 32'h0,        32'h34, 1'b1, 32'h00000009, 32'h00000000, 1'b0}; // addi $0,$0,9
        vecs[14] = '{32'h08E00000, 32'h0,        32'h38, 1'b1, 32'h00000004, 32'h00000000, 1'b1}; // sw $0,0($7)
        vecs[15] = '{32'h18220010, 32'h0,        32'h3C, 1'b1, 32'h00000015, 32'h00000007, 1'b0}; // op 6 = NOP
        vecs[16] = '{32'h00420821, 32'h0,        32'h40, 1'b0, 32'h00000000, 32'h00000007, 1'b0}; // funct 0x21 = NOP
        vecs[17] = '{32'h0C28FFFF, 32'h0,        32'h44, 1'b1, 32'h00000004, 32'h00000000, 1'b0}; // addi $8,$1,-1
        vecs[18] = '{32'h10220003, 32'h0,        32'h48, 1'b1, 32'hFFFFFFFE, 32'h00000007, 1'b0}; // beq $1,$2 not taken
        vecs[19] = '{32'h1021FFFE, 32'h0,        32'h4C, 1'b1, 32'h00000000, 32'h00000005, 1'b0}; // beq $1,$1,-2
        vecs[20] = '{32'h14000040, 32'h0,        32'h48, 1'b1, 32'h00000040, 32'h00000000, 1'b0}; // j 0x40
        vecs[21] = '{32'h10210002, 32'h0,        32'h100, 1'b1, 32'h00000000, 32'h00000005, 1'b0}; // beq $1,$1,+2
        vecs[22] = '{32'h0429FFFC, 32'hA5A5A5A5, 32'h10C, 1'b1, 32'h00000001, 32'h00000000, 1'b0}; // lw $9,-4($1)
        vecs[23] = '{32'h08090000, 32'h0,        32'h110, 1'b1, 32'h00000000, 32'hA5A5A5A5, 1'b1}; // sw $9,0($0)

        // ---- reset held: pc at RESET_PC, store suppressed, across an edge
        reset    = 1'b0;
        instr    = 32'h09820004;
        readdata = 32'h0;
        #1;
        n_vec++;
        show("reset");
        chk("reset_pc", pc, 32'h0);
        chk("reset_mw", {31'b0, memwrite}, 32'h0);
        chk("reset_wd", writedata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        show("reset_hold");
        chk("reset_hold_pc", pc, 32'h0);

        // ---- table-driven program
        for (int i = 0; i < 24; i++) begin
            if (i != 0) @(negedge clk);
            reset    = 1'b1;
            instr    = vecs[i].instr;
            readdata = vecs[i].rdata;
            #1;
            n_vec++;
            show($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            if (vecs[i].chk_alu)
                chk($sformatf("vec%0d_aluout", i), aluout, vecs[i].exp_alu);
            chk($sformatf("vec%0d_wdata", i), writedata, vecs[i].exp_wd);
            chk($sformatf("vec%0d_memwrite", i), {31'b0, memwrite}, {31'b0, vecs[i].exp_mw});
        end

        // ---- final pc after last table row
        @(negedge clk);
        n_vec++;
        show("after_table");
        chk("after_table_pc", pc, 32'h114);

        // ---- reset asserted mid-cycle: pending addi $10 discarded, pc to 0 at once
        instr = 32'h0C0A0077;
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        show("midreset");
        chk("midreset_pc", pc, 32'h0);

        // registers cleared: sw $9,0($1) reads RF1=0, RF9=0, memwrite forced 0
        instr = 32'h08290000;
        #1;
        n_vec++;
        show("midreset_rf");
        chk("midreset_alu", aluout, 32'h0);
        chk("midreset_wd", writedata, 32'h0);
        chk("midreset_mw", {31'b0, memwrite}, 32'h0);

        // release; sw $10,0($6): $10 must not hold the discarded 0x77
        @(negedge clk);
        reset = 1'b1;
        instr = 32'h08CA0000;
        #1;
        n_vec++;
        show("post_reset");
        chk("post_reset_pc", pc, 32'h0);
        chk("post_reset_alu", aluout, 32'h0);
        chk("post_reset_wd", writedata, 32'h0);
        chk("post_reset_mw", {31'b0, memwrite}, 32'h1);
        @(negedge clk);
        n_vec++;
        show("post_reset_step");
        chk("post_reset_step_pc", pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
